// File: rtl/spi_deserializer_if.sv
// spi_deserializer_if: one-entry frame buffer handshake between the SPI
// deserializer (master, presents frames) and the request queue (slave, accepts).
interface spi_deserializer_if #(
   parameter int OPCODEW = 2,
   parameter int ADDRW   = 8
);
   logic               ready_in;
   logic               valid_out;
   logic [OPCODEW-1:0] opcode_out;
   logic [ADDRW-1:0]   addr_out;

   modport master (
      input  ready_in,
      output valid_out,
      output opcode_out,
      output addr_out
   );

   modport slave (
      output ready_in,
      input  valid_out,
      input  opcode_out,
      input  addr_out
   );
endinterface

// File: rtl/spi_deserializer.sv
// spi_deserializer: receives opcode+address frames shifted in MSB first on
// mosi under a slow external spi_clk framed by active-low cs_n. Every flop runs
// on clk; the SPI pins are synchronized and edge-detected. Completed frames go
// to a one-entry valid/ready buffer.
// Optional feature: define SPI_DESER_PARITY_EN to expect one extra even-parity
// bit per frame; frames with a parity mismatch are dropped with parity_err.
module spi_deserializer #(
   parameter int ADDRW   = 8,
   parameter int OPCODEW = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                spi_clk,
   input  logic                cs_n,
   input  logic                mosi,
   spi_deserializer_if.master  out_if,
   output logic                overflow,
   output logic                frame_err,
   output logic                parity_err
);

   localparam int FW = OPCODEW + ADDRW;
`ifdef SPI_DESER_PARITY_EN
   localparam int NBITS = FW + 1;
`else
   localparam int NBITS = FW;
`endif
   localparam int CNTW = $clog2(FW + 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Synchronizer chains (s1/s2 for metastability, s3 = previous sample)
   logic sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_s3_q, sclk_s3_d;
   logic cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d, cs_s3_q, cs_s3_d;
   logic mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;

   // Counts the cycles after reset until the chains hold only real pin samples
   logic [1:0] prime_q, prime_d;
   logic       primed;

   logic rise, cs_fall, cs_rise;

   state_t             state_q, state_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic [NBITS-1:0]   shift_q, shift_d;
   logic               valid_q, valid_d;
   logic [OPCODEW-1:0] opcode_q, opcode_d;
   logic [ADDRW-1:0]   addr_q, addr_d;
   logic               overflow_q, overflow_d;
   logic               frame_err_q, frame_err_d;
   logic               frame_done;
   logic               frame_ok;
   logic               drain;

   // Next values for the pin synchronizers and the post-reset priming counter
   always_comb begin
      sclk_s1_d = spi_clk;
      sclk_s2_d = sclk_s1_q;
      sclk_s3_d = sclk_s2_q;
      cs_s1_d   = cs_n;
      cs_s2_d   = cs_s1_q;
      cs_s3_d   = cs_s2_q;
      mosi_s1_d = mosi;
      mosi_s2_d = mosi_s1_q;
      prime_d   = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
   end

   // Synchronizer flops; reset to the idle pin levels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_s1_q <= 1'b0;
         sclk_s2_q <= 1'b0;
         sclk_s3_q <= 1'b0;
         cs_s1_q   <= 1'b1;
         cs_s2_q   <= 1'b1;
         cs_s3_q   <= 1'b1;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
         prime_q   <= 2'd0;
      end else begin
         sclk_s1_q <= sclk_s1_d;
         sclk_s2_q <= sclk_s2_d;
         sclk_s3_q <= sclk_s3_d;
         cs_s1_q   <= cs_s1_d;
         cs_s2_q   <= cs_s2_d;
         cs_s3_q   <= cs_s3_d;
         mosi_s1_q <= mosi_s1_d;
         mosi_s2_q <= mosi_s2_d;
         prime_q   <= prime_d;
      end
   end

   // Edges are only trusted once the reset values have been flushed out of the
   // chains; otherwise cs_n held low across reset release would look like a
   // fresh cs_fall and start a bogus frame.
   assign primed  = (prime_q == 2'd3);
   assign rise    = primed &  sclk_s2_q & ~sclk_s3_q;
   assign cs_fall = primed & ~cs_s2_q   &  cs_s3_q;
   assign cs_rise = primed &  cs_s2_q   & ~cs_s3_q;

   assign drain = valid_q & out_if.ready_in;

`ifdef SPI_DESER_PARITY_EN
   logic parity_err_q, parity_err_d;
`endif

   // FSM next state, shift/count datapath and output buffer update
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      valid_d     = valid_q;
      opcode_d    = opcode_q;
      addr_d      = addr_q;
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
      frame_done  = 1'b0;
      frame_ok    = 1'b1;
`ifdef SPI_DESER_PARITY_EN
      parity_err_d = 1'b0;
`endif

      if (drain) begin
         valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               cnt_d   = '0;
               shift_d = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               frame_err_d = 1'b1;
               cnt_d       = '0;
               shift_d     = '0;
               state_d     = IDLE;
            end else if (rise && !cs_s2_q) begin
               shift_d = {shift_q[NBITS-2:0], mosi_s2_q};
               cnt_d   = cnt_q + CNTW'(1);
               if (cnt_q == CNTW'(NBITS - 1)) begin
                  frame_done = 1'b1;
                  state_d    = HOLD;
               end
            end
         end
         HOLD: begin
            if (cs_rise) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef SPI_DESER_PARITY_EN
      frame_ok = ~(^shift_d);
`endif

      if (frame_done) begin
         if (!frame_ok) begin
`ifdef SPI_DESER_PARITY_EN
            parity_err_d = 1'b1;
`endif
         end else if (!valid_q || drain) begin
            valid_d  = 1'b1;
            opcode_d = shift_d[NBITS-1 -: OPCODEW];
            addr_d   = shift_d[NBITS-1-OPCODEW -: ADDRW];
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   // State, datapath and output-buffer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         valid_q     <= 1'b0;
         opcode_q    <= '0;
         addr_q      <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         valid_q     <= valid_d;
         opcode_q    <= opcode_d;
         addr_q      <= addr_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef SPI_DESER_PARITY_EN
   // Parity error pulse register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign out_if.valid_out  = valid_q;
   assign out_if.opcode_out = opcode_q;
   assign out_if.addr_out   = addr_q;
   assign overflow          = overflow_q;
   assign frame_err         = frame_err_q;

endmodule
